// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store initiator.
// State encoding, access-size codes and byte-lane width.
package mem_access_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational lane logic: extracts/extends load data from a memory word and
// merges sub-word store data into a word (little-endian lanes).
module mem_lane_unit
  import mem_access_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       addr_lo,
  input  logic [1:0]       size,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] store_word
);

  localparam int HALF_W = 2 * BYTE_W;
  localparam int SHW    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] BYTE_MASK = {{(WIDTH-BYTE_W){1'b0}}, {BYTE_W{1'b1}}};
  localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-HALF_W){1'b0}}, {HALF_W{1'b1}}};

  logic [SHW-1:0]    byte_sh;
  logic [SHW-1:0]    half_sh;
  logic [BYTE_W-1:0] lane_b;
  logic [HALF_W-1:0] lane_h;

  assign byte_sh = SHW'({addr_lo, 3'b000});
  assign half_sh = SHW'({addr_lo[1], 4'b0000});
  assign lane_b  = word[byte_sh +: BYTE_W];
  assign lane_h  = word[half_sh +: HALF_W];

  always_comb begin
    load_data  = word;
    store_word = wdata;
    case (size)
      SZ_B: begin
        load_data  = is_unsigned ? {{(WIDTH-BYTE_W){1'b0}}, lane_b}
                                 : {{(WIDTH-BYTE_W){lane_b[BYTE_W-1]}}, lane_b};
        store_word = (word & ~(BYTE_MASK << byte_sh)) | ((wdata & BYTE_MASK) << byte_sh);
      end
      SZ_H: begin
        load_data  = is_unsigned ? {{(WIDTH-HALF_W){1'b0}}, lane_h}
                                 : {{(WIDTH-HALF_W){lane_h[HALF_W-1]}}, lane_h};
        store_word = (word & ~(HALF_MASK << half_sh)) | ((wdata & HALF_MASK) << half_sh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator: byte-addressed core requests to single-cycle mem_r/mem_w
// strobes, read-modify-write for sub-word stores, bounded wait on mem_done.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 32,
  parameter int MEMSIZE  = 256,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDRSIZE-1:0] req_addr,
  input  logic [WIDTH-1:0]    req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_rdata,
  output logic                rsp_err,
  output logic                mem_r,
  output logic                mem_w,
  output logic [ADDRSIZE-1:0] data_addr,
  output logic [WIDTH-1:0]    data_in,
  input  logic [WIDTH-1:0]    data_out,
  input  logic                mem_done
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [CW-1:0]    wait_cnt;
  logic             a_we;
  logic             a_uns;
  logic [1:0]       a_size;
  logic [1:0]       a_lo;
  logic [WIDTH-1:0] a_wdata;

  logic             acc_err;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] merged_word;

  assign acc_err = (req_size == SZ_ILL)
                || (req_size == SZ_H && req_addr[0])
                || (req_size == SZ_W && req_addr[1:0] != 2'b00)
                || ((req_addr >> 2) >= ADDRSIZE'(MEMSIZE));

  // Lane unit always works on the live memory word; results are registered
  // in the cycle mem_done is seen.
  mem_lane_unit #(.WIDTH(WIDTH)) u_lane (
    .word        (data_out),
    .addr_lo     (a_lo),
    .size        (a_size),
    .is_unsigned (a_uns),
    .wdata       (a_wdata),
    .load_data   (load_data),
    .store_word  (merged_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      a_we      <= 1'b0;
      a_uns     <= 1'b0;
      a_size    <= SZ_B;
      a_lo      <= 2'b00;
      a_wdata   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_r     <= 1'b0;
      mem_w     <= 1'b0;
      data_addr <= '0;
      data_in   <= '0;
    end else begin
      mem_r <= 1'b0;
      mem_w <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            a_we      <= req_we;
            a_uns     <= req_unsigned;
            a_size    <= req_size;
            a_lo      <= req_addr[1:0];
            a_wdata   <= req_wdata;
            wait_cnt  <= '0;
            if (acc_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_we && req_size == SZ_W) begin
              state     <= WR;
              mem_w     <= 1'b1;
              data_addr <= req_addr >> 2;
              data_in   <= req_wdata;
            end else begin
              state     <= RD;
              mem_r     <= 1'b1;
              data_addr <= req_addr >> 2;
            end
          end
        end

        RD: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end

        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (mem_done) begin
            if (a_we) begin
              state   <= WR;
              mem_w   <= 1'b1;
              data_in <= merged_word;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= load_data;
            end
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            // Timed out: a pending sub-word store is abandoned without writing.
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end

        WR: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: word memory responder plus a byte-array reference
// model; directed scenarios followed by randomized accesses.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_r, mem_w, mem_done;
  logic [31:0] data_addr, data_in, data_out;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_r(mem_r), .mem_w(mem_w), .data_addr(data_addr), .data_in(data_in),
    .data_out(data_out), .mem_done(mem_done)
  );

  // Word memory responder: mem_done one cycle after mem_r, writes on mem_w.
  logic [31:0] mem_words [0:255];
  logic        mem_clear = 1'b1;
  logic        done_en   = 1'b1;
  logic        pend = 1'b0, prev_r = 1'b0, prev_w = 1'b0;
  logic [31:0] pend_data = '0;
  int          rd_cnt = 0, wr_cnt = 0, viol = 0;
  logic [31:0] last_w_addr = '0, last_w_data = '0;

  initial begin
    mem_done = 1'b0;
    data_out = '0;
  end

  always @(posedge clk) begin
    #1;
    if (mem_clear) foreach (mem_words[i]) mem_words[i] = '0;
    mem_done = pend & done_en;
    data_out = pend_data;
    if (mem_r && mem_w) viol++;
    if ((mem_r && prev_r) || (mem_w && prev_w)) viol++;
    prev_r = mem_r;
    prev_w = mem_w;
    if (mem_w) begin
      wr_cnt++;
      last_w_addr = data_addr;
      last_w_data = data_in;
      if (data_addr < 256) mem_words[data_addr[7:0]] = data_in;
    end
    pend = mem_r;
    if (mem_r) begin
      rd_cnt++;
      pend_data = (data_addr < 256) ? mem_words[data_addr[7:0]] : 32'h0;
    end
  end

  // Reference model: flat byte-addressed memory of 1024 bytes.
  logic [7:0] refb [0:1023];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ref_access(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er, output int lat);
    int n;
    logic [31:0] v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00)
      || (addr >= 32'd1024);
    rd = '0;
    if (er) lat = 1;
    else if (we) begin
      for (int i = 0; i < n; i++) refb[addr + i] = wd[8*i +: 8];
      lat = (n == 4) ? 2 : 4;
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = refb[addr + i];
      if (!uns && n < 4 && v[8*n-1])
        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      rd  = v;
      lat = 3;
    end
  endtask

  task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; rsp_ready = (hold == 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wdata = $urandom();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 40);
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_err", rsp_err, er);
      chk("hold_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd, input int hold,
                     output logic [31:0] rd);
    logic [31:0] erd;
    logic        eer, er;
    int          elat, lat;
    ref_access(we, sz, uns, addr, wd, erd, eer, elat);
    access(we, sz, uns, addr, wd, hold, rd, er, lat);
    chk({tag, "_err"}, er, eer);
    chk({tag, "_rdata"}, rd, erd);
    chk({tag, "_lat"}, lat, elat);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, r0, w0;

    foreach (refb[i]) refb[i] = 8'h00;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_clear = 1'b0;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_mem_r", mem_r, 1'b0);
    chk("rst_mem_w", mem_w, 1'b0);
    chk("rst_data_addr", data_addr, 32'h0);
    chk("rst_data_in", data_in, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1'b1);

    // Word store then load
    w0 = wr_cnt;
    run("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd);
    chk("sw_10_wcnt", wr_cnt - w0, 1);
    chk("sw_10_waddr", last_w_addr, 32'd4);
    chk("sw_10_wdata", last_w_data, 32'hDEADBEEF);
    run("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd);
    chk("lw_10_val", rd, 32'hDEADBEEF);

    // Load extension
    run("lb_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, rd);
    chk("lb_13_val", rd, 32'hFFFFFFDE);
    run("lbu_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, rd);
    chk("lbu_13_val", rd, 32'h000000DE);
    run("lh_10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0, rd);
    chk("lh_10_val", rd, 32'hFFFFBEEF);

    // Half store merge
    r0 = rd_cnt; w0 = wr_cnt;
    run("sh_12", 1'b1, 2'b01, 1'b0, 32'h12, 32'hCAFE1234, 0, rd);
    chk("sh_12_rcnt", rd_cnt - r0, 1);
    chk("sh_12_wcnt", wr_cnt - w0, 1);
    chk("sh_12_merge", last_w_data, 32'h1234BEEF);

    // Error requests: no strobes at all
    r0 = rd_cnt; w0 = wr_cnt;
    run("err_lw_2", 1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 0, rd);
    run("err_sh_11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h55, 0, rd);
    run("err_size3", 1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 0, rd);
    run("err_range", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 0, rd);
    chk("err_no_mem_r", rd_cnt - r0, 0);
    chk("err_no_mem_w", wr_cnt - w0, 0);

    // Timeout with held response
    done_en = 1'b0;
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, rd, er, lat);
    chk("to_err", er, 1'b1);
    chk("to_rdata", rd, 32'h0);
    chk("to_lat", lat, 2 + 15);
    done_en = 1'b1;

    // Reset during WAIT of a sub-word store
    w0 = wr_cnt;
    done_en = 1'b0;
    @(negedge clk);
    chk("mr_req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_mem_w", mem_w, 1'b0);
    chk("mr_mem_r", mem_r, 1'b0);
    chk("mr_rsp_valid", rsp_valid, 1'b0);
    chk("mr_req_ready", req_ready, 1'b0);
    chk("mr_data_addr", data_addr, 32'h0);
    chk("mr_rsp_err", rsp_err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("mr_ready_after", req_ready, 1'b1);
    chk("mr_no_write", wr_cnt - w0, 0);
    done_en = 1'b1;
    run("mr_lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd);
    chk("mr_lw_10_val", rd, 32'h1234BEEF);

    // Randomized accesses
    for (int k = 0; k < 150; k++) begin
      logic [31:0] a;
      logic [1:0]  s;
      s = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(1024, 1100))
                                        : 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'b01) a[0] = 1'b0;
        if (s == 2'b10) a[1:0] = 2'b00;
      end
      run("rnd", 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom(),
          $urandom_range(0, 3) == 0 ? 2 : 0, rd);
    end

    chk("strobe_rules", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
